// File: rtl/blake2s_block_seq.sv
// blake2s_block_seq: cuts a valid/ready byte stream into zero-padded 64-byte blocks for the BLAKE2s core.
// Keyed mode (KEY state, core_kk_o) is built only when BLAKE2_KEY_EN is defined; otherwise core_kk_o is 0.
module blake2s_block_seq #(
  parameter int BLOCK_W = 64,
  parameter int LL_W    = 64
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       cfg_v_i,
  input  logic [5:0]                 cfg_kk_i,
  input  logic [5:0]                 cfg_nn_i,
  input  logic                       cfg_empty_i,
  input  logic                       s_valid_i,
  input  logic [7:0]                 s_data_i,
  input  logic                       s_last_i,
  output logic                       s_ready_o,
  input  logic                       core_ready_v_i,
  output logic [5:0]                 core_kk_o,
  output logic [5:0]                 core_nn_o,
  output logic [LL_W-1:0]            core_ll_o,
  output logic                       core_data_v_o,
  output logic [7:0]                 core_data_o,
  output logic [$clog2(BLOCK_W)-1:0] core_data_idx_o,
  output logic                       core_block_first_o,
  output logic                       core_block_last_o,
  output logic                       busy_o
);

  localparam int IDX_W = $clog2(BLOCK_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_W - 1);

`ifdef BLAKE2_KEY_EN
  typedef enum logic [2:0] {IDLE, WAIT, KEY, DATA, PAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT, DATA, PAD} state_t;
`endif

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             skip_wait;
  logic             first_r;
  logic             final_r;
  logic             empty_r;
  logic             emit_v;
  logic [7:0]       emit_byte;
  logic             emit_last;

`ifdef BLAKE2_KEY_EN
  logic             key_sent;
  logic [IDX_W-1:0] key_end;
  assign key_end   = IDX_W'(core_kk_o) - IDX_W'(1);
  assign s_ready_o = (state == DATA) || (state == KEY);
`else
  logic unused_kk;
  assign unused_kk = ^cfg_kk_i;
  assign core_kk_o = '0;
  assign s_ready_o = (state == DATA);
`endif

  // Byte leaving for the core this cycle; last is sticky once s_last has been seen.
  always_comb begin
    emit_v    = 1'b0;
    emit_byte = 8'h00;
    emit_last = final_r;
    unique case (state)
`ifdef BLAKE2_KEY_EN
      KEY: begin
        emit_v    = s_valid_i;
        emit_byte = s_data_i;
      end
`endif
      DATA: begin
        emit_v    = s_valid_i;
        emit_byte = s_data_i;
        emit_last = final_r | s_last_i;
      end
      PAD:     emit_v = 1'b1;
      default: emit_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state              <= IDLE;
      idx                <= '0;
      skip_wait          <= 1'b0;
      first_r            <= 1'b0;
      final_r            <= 1'b0;
      empty_r            <= 1'b0;
`ifdef BLAKE2_KEY_EN
      key_sent           <= 1'b0;
      core_kk_o          <= '0;
`endif
      core_nn_o          <= '0;
      core_ll_o          <= '0;
      core_data_v_o      <= 1'b0;
      core_data_o        <= '0;
      core_data_idx_o    <= '0;
      core_block_first_o <= 1'b0;
      core_block_last_o  <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      core_data_v_o <= 1'b0;
      if (emit_v) begin
        core_data_v_o      <= 1'b1;
        core_data_o        <= emit_byte;
        core_data_idx_o    <= idx;
        core_block_first_o <= first_r;
        core_block_last_o  <= emit_last;
        idx                <= idx + 1'b1;
        if (idx == IDX_LAST) first_r <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (cfg_v_i && !busy_o) begin
            state     <= WAIT;
            skip_wait <= 1'b1;
            first_r   <= 1'b1;
            final_r   <= 1'b0;
            empty_r   <= cfg_empty_i;
            core_nn_o <= cfg_nn_i;
            core_ll_o <= '0;
            busy_o    <= 1'b1;
`ifdef BLAKE2_KEY_EN
            core_kk_o <= cfg_kk_i;
            key_sent  <= 1'b0;
`endif
          end
        end
        // The core still reports ready on the cycle right after idx 63, so skip it.
        WAIT: begin
          if (skip_wait) begin
            skip_wait <= 1'b0;
          end else if (core_ready_v_i) begin
            idx <= '0;
`ifdef BLAKE2_KEY_EN
            if (core_kk_o != '0 && !key_sent) begin
              state     <= KEY;
              key_sent  <= 1'b1;
              final_r   <= empty_r;
              core_ll_o <= core_ll_o + LL_W'(BLOCK_W);
            end else
`endif
            if (empty_r) begin
              state   <= PAD;
              final_r <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
`ifdef BLAKE2_KEY_EN
        KEY: begin
          if (s_valid_i && idx == key_end) state <= PAD;
        end
`endif
        DATA: begin
          if (s_valid_i) begin
            core_ll_o <= core_ll_o + 1'b1;
            if (s_last_i) final_r <= 1'b1;
            if (idx == IDX_LAST) begin
              state     <= s_last_i ? IDLE : WAIT;
              skip_wait <= 1'b1;
            end else if (s_last_i) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (idx == IDX_LAST) begin
            state     <= final_r ? IDLE : WAIT;
            skip_wait <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2s_block_seq.sv
// Directed bench for blake2s_block_seq: emitted bytes are captured per block and compared with hand-built expectations.
module tb_blake2s_block_seq;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cfg_v = 1'b0;
  logic [5:0]  cfg_kk = '0;
  logic [5:0]  cfg_nn = '0;
  logic        cfg_empty = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        core_ready = 1'b1;
  logic [5:0]  core_kk;
  logic [5:0]  core_nn;
  logic [63:0] core_ll;
  logic        core_data_v;
  logic [7:0]  core_data;
  logic [5:0]  core_idx;
  logic        core_first;
  logic        core_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [79:0] cap [256];
  int          n = 0;
  bit          rdy_seen = 1'b0;

  blake2s_block_seq #(.BLOCK_W(64), .LL_W(64)) dut (
    .clk(clk), .nreset(nreset),
    .cfg_v_i(cfg_v), .cfg_kk_i(cfg_kk), .cfg_nn_i(cfg_nn), .cfg_empty_i(cfg_empty),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
    .core_ready_v_i(core_ready), .core_kk_o(core_kk), .core_nn_o(core_nn), .core_ll_o(core_ll),
    .core_data_v_o(core_data_v), .core_data_o(core_data), .core_data_idx_o(core_idx),
    .core_block_first_o(core_first), .core_block_last_o(core_last), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_ready) rdy_seen = 1'b1;
    if (core_data_v && n < 256) begin
      cap[n] = {core_data, core_idx, core_first, core_last, core_ll};
      n = n + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clear_cap;
    for (int i = 0; i < 256; i++) cap[i] = 'x;
    n = 0;
  endtask

  task automatic do_cfg(input logic [5:0] kk, input logic empty);
    cfg_v = 1'b1; cfg_kk = kk; cfg_nn = 6'd32; cfg_empty = empty;
    @(negedge clk);
    cfg_v = 1'b0; cfg_empty = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1; s_data = b; s_last = last;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_byte: byte %h not accepted within 300 cycles, required acceptance", b);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s idle: busy_o=%b after 1000 cycles, required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    #12;
    checks++;
    if ({s_ready, core_kk, core_nn, core_ll, core_data_v, core_data, core_idx, core_first, core_last, busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs: ready=%b kk=%h nn=%h ll=%h v=%b d=%h idx=%h f=%b l=%b busy=%b, required all 0",
               s_ready, core_kk, core_nn, core_ll, core_data_v, core_data, core_idx, core_first, core_last, busy);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc;
    logic [79:0] exp;
    logic [7:0]  ed;
    logic [63:0] ell;
    clear_cap();
    do_cfg(6'd0, 1'b0);
    checks++;
    if (core_nn !== 6'd32 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abc cfg latch: nn=%0d busy=%b, required nn=32 busy=1", core_nn, busy);
    end
    push_byte(8'h61, 1'b0); push_byte(8'h62, 1'b0); push_byte(8'h63, 1'b1);
    wait_idle("abc");
    checks++;
    if (n !== 64) begin errors++; $display("FAIL abc byte count: got %0d, required 64", n); end
    for (int i = 0; i < 64; i++) begin
      ed  = (i < 3) ? 8'(8'h61 + i) : 8'h00;
      ell = (i < 3) ? 64'(i + 1) : 64'd3;
      exp = {ed, 6'(i), 1'b1, (i >= 2), ell};
      checks++;
      if (cap[i] !== exp) begin errors++; $display("FAIL abc byte %0d: got %h, required %h", i, cap[i], exp); end
    end
  endtask

  task automatic test_full_block;
    logic [79:0] exp;
    clear_cap();
    do_cfg(6'd0, 1'b0);
    for (int i = 0; i < 64; i++) push_byte(8'(i ^ 8'h5A), (i == 63));
    checks++;
    if ({core_data_v, core_idx, busy} !== {1'b1, 6'd63, 1'b1}) begin
      errors++;
      $display("FAIL full final byte: v=%b idx=%0d busy=%b, required v=1 idx=63 busy=1", core_data_v, core_idx, busy);
    end
    @(negedge clk);
    checks++;
    if ({core_data_v, busy} !== 2'b00) begin
      errors++;
      $display("FAIL full busy drop: v=%b busy=%b, required 0 0 (no pad)", core_data_v, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL full byte count: got %0d, required 64", n); end
    for (int i = 0; i < 64; i++) begin
      exp = {8'(i ^ 8'h5A), 6'(i), 1'b1, (i == 63), 64'(i + 1)};
      checks++;
      if (cap[i] !== exp) begin errors++; $display("FAIL full byte %0d: got %h, required %h", i, cap[i], exp); end
    end
  endtask

  task automatic test_stall;
    logic [79:0] exp;
    logic [7:0]  ed;
    clear_cap();
    do_cfg(6'd0, 1'b0);
    for (int i = 0; i < 64; i++) push_byte(8'(i * 3 + 1), 1'b0);
    core_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'(64 * 3 + 1); s_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL stall ready cycle %0d: got %b, required 0", c, s_ready); end
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL stall bytes during stall: got %0d, required 64", n); end
    core_ready = 1'b1;
    push_byte(8'(64 * 3 + 1), 1'b1);
    wait_idle("stall");
    checks++;
    if (n !== 128) begin errors++; $display("FAIL stall byte count: got %0d, required 128", n); end
    for (int i = 0; i < 128; i++) begin
      if (i < 64)       exp = {8'(i * 3 + 1), 6'(i), 1'b1, 1'b0, 64'(i + 1)};
      else begin
        ed  = (i == 64) ? 8'(64 * 3 + 1) : 8'h00;
        exp = {ed, 6'(i - 64), 1'b0, 1'b1, 64'd65};
      end
      checks++;
      if (cap[i] !== exp) begin errors++; $display("FAIL stall byte %0d: got %h, required %h", i, cap[i], exp); end
    end
  endtask

  task automatic test_empty;
    logic [79:0] exp;
    clear_cap();
    rdy_seen = 1'b0;
    do_cfg(6'd0, 1'b1);
    wait_idle("empty");
    checks++;
    if (n !== 64) begin errors++; $display("FAIL empty byte count: got %0d, required 64", n); end
    checks++;
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL empty s_ready seen: got %b, required 0", rdy_seen); end
    for (int i = 0; i < 64; i++) begin
      exp = {8'h00, 6'(i), 1'b1, 1'b1, 64'd0};
      checks++;
      if (cap[i] !== exp) begin errors++; $display("FAIL empty byte %0d: got %h, required %h", i, cap[i], exp); end
    end
  endtask

`ifdef BLAKE2_KEY_EN
  task automatic test_key;
    logic [79:0] exp;
    logic [7:0]  ed;
    int          k;
    clear_cap();
    do_cfg(6'd2, 1'b0);
    checks++;
    if (core_kk !== 6'd2) begin errors++; $display("FAIL key kk latch: got %0d, required 2", core_kk); end
    push_byte(8'hAA, 1'b1); push_byte(8'hBB, 1'b0);
    push_byte(8'h61, 1'b0); push_byte(8'h62, 1'b0); push_byte(8'h63, 1'b1);
    wait_idle("key");
    checks++;
    if (n !== 128) begin errors++; $display("FAIL key byte count: got %0d, required 128", n); end
    for (int i = 0; i < 128; i++) begin
      if (i < 64) begin
        ed  = (i == 0) ? 8'hAA : (i == 1) ? 8'hBB : 8'h00;
        exp = {ed, 6'(i), 1'b1, 1'b0, 64'd64};
      end else begin
        k   = i - 64;
        ed  = (k < 3) ? 8'(8'h61 + k) : 8'h00;
        exp = {ed, 6'(k), 1'b0, (k >= 2), (k < 3) ? 64'(65 + k) : 64'd67};
      end
      checks++;
      if (cap[i] !== exp) begin errors++; $display("FAIL key byte %0d: got %h, required %h", i, cap[i], exp); end
    end
  endtask
`else
  task automatic test_kk_ignored;
    logic [79:0] exp;
    clear_cap();
    do_cfg(6'd5, 1'b0);
    checks++;
    if (core_kk !== 6'd0) begin errors++; $display("FAIL kk ignored: core_kk_o=%0d, required 0", core_kk); end
    push_byte(8'h7A, 1'b1);
    wait_idle("kk_ignored");
    checks++;
    if (n !== 64) begin errors++; $display("FAIL kk ignored byte count: got %0d, required 64", n); end
    exp = {8'h7A, 6'd0, 1'b1, 1'b1, 64'd1};
    checks++;
    if (cap[0] !== exp) begin errors++; $display("FAIL kk ignored byte 0: got %h, required %h", cap[0], exp); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [79:0] exp;
    clear_cap();
    do_cfg(6'd0, 1'b0);
    for (int i = 0; i < 21; i++) push_byte(8'(i + 1), 1'b0);
    checks++;
    if ({core_data_v, core_idx} !== {1'b1, 6'd20}) begin
      errors++;
      $display("FAIL midreset pre: v=%b idx=%0d, required v=1 idx=20", core_data_v, core_idx);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({s_ready, core_kk, core_nn, core_ll, core_data_v, core_data, core_idx, core_first, core_last, busy} !== '0) begin
      errors++;
      $display("FAIL midreset outputs: ready=%b ll=%h v=%b d=%h idx=%0d f=%b l=%b busy=%b, required all 0",
               s_ready, core_ll, core_data_v, core_data, core_idx, core_first, core_last, busy);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    clear_cap();
    do_cfg(6'd0, 1'b0);
    push_byte(8'h41, 1'b1);
    wait_idle("midreset restart");
    checks++;
    if (n !== 64) begin errors++; $display("FAIL midreset restart count: got %0d, required 64", n); end
    exp = {8'h41, 6'd0, 1'b1, 1'b1, 64'd1};
    checks++;
    if (cap[0] !== exp) begin errors++; $display("FAIL midreset restart byte 0: got %h, required %h", cap[0], exp); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_block();
    test_stall();
    test_empty();
`ifdef BLAKE2_KEY_EN
    test_key();
`else
    test_kk_ignored();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
